// File: rtl/mask_stream_loader.sv
// Fetches NUM_BEATS consecutive words over Avalon-MM with pipelined reads into a shadow
// buffer, then commits them to mask in one cycle. A watchdog aborts stalled loads.
module mask_stream_loader #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned NUM_BEATS = 9,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                          iCLK,
    input  logic                          reset,
    input  logic                          load_ddr,
    input  logic [ADDR_W-1:0]             start_address,
    output logic                          ready,
    output logic                          done,
    output logic                          error,
    output logic [NUM_BEATS*DATA_W-1:0]   mask,
    output logic [ADDR_W-1:0]             avl_address,
    output logic                          avl_read,
    output logic                          avl_burstbegin,
    output logic                          avl_write,
    output logic [DATA_W-1:0]             avl_writedata,
    input  logic                          avl_wait_request_n,
    input  logic [DATA_W-1:0]             avl_readdata,
    input  logic                          avl_readdatavalid
);

    localparam int unsigned CNT_W  = $clog2(NUM_BEATS + 1);
    localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT);
    localparam int unsigned MASK_W = NUM_BEATS * DATA_W;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StCommit = 2'd2;

    localparam logic [CNT_W-1:0]  BeatsC    = CNT_W'(NUM_BEATS);
    localparam logic [CNT_W-1:0]  LastBeatC = CNT_W'(NUM_BEATS - 1);
    localparam logic [OUT_W-1:0]  MaxOutC   = OUT_W'(MAX_OUT);
    localparam logic [WDOG_W-1:0] WdogLastC = WDOG_W'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_resp_cnt;
    logic [OUT_W-1:0]   r_out_cnt;
    logic [WDOG_W-1:0]  r_wdog;
    logic               r_done;
    logic               r_error;
    logic [MASK_W-1:0]  r_mask;
    logic [MASK_W-1:0]  r_shadow;

    logic w_run;
    logic w_read;
    logic w_accept;
    logic w_beat;
    logic w_last_beat;
    logic w_timeout;

    always_comb begin
        w_run       = (r_state == StRun);
        w_read      = w_run && (r_issue_cnt < BeatsC) && (r_out_cnt < MaxOutC);
        w_accept    = w_read && avl_wait_request_n;
        // Beats outside RUN (late returns after abort or reset) are dropped here.
        w_beat      = w_run && avl_readdatavalid;
        w_last_beat = w_beat && (r_resp_cnt == LastBeatC);
        w_timeout   = w_run && !w_accept && !w_beat && (r_wdog == WdogLastC);
    end

    always_ff @(posedge iCLK) begin
        if (reset) begin
            r_state     <= StIdle;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
            r_out_cnt   <= '0;
            r_wdog      <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_mask      <= '0;
            r_shadow    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (load_ddr) begin
                        r_base      <= start_address;
                        r_issue_cnt <= '0;
                        r_resp_cnt  <= '0;
                        r_out_cnt   <= '0;
                        r_wdog      <= '0;
                        r_error     <= 1'b0;
                        r_state     <= StRun;
                    end
                end
                StRun: begin
                    if (w_accept) begin
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                    end
                    unique case ({w_accept, w_beat})
                        2'b10:   r_out_cnt <= r_out_cnt + OUT_W'(1);
                        2'b01:   r_out_cnt <= r_out_cnt - OUT_W'(1);
                        default: r_out_cnt <= r_out_cnt;
                    endcase
                    if (w_beat) begin
                        r_resp_cnt <= r_resp_cnt + CNT_W'(1);
                    end
                    for (int unsigned k = 0; k < NUM_BEATS; k++) begin
                        if (w_beat && (r_resp_cnt == CNT_W'(k))) begin
                            r_shadow[k*DATA_W +: DATA_W] <= avl_readdata;
                        end
                    end
                    if (w_accept || w_beat) begin
                        r_wdog <= '0;
                    end else if (!w_timeout) begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                    if (w_last_beat) begin
                        r_state <= StCommit;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= StIdle;
                    end
                end
                StCommit: begin
                    r_mask  <= r_shadow;
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ready          = (r_state == StIdle);
    assign done           = r_done;
    assign error          = r_error;
    assign mask           = r_mask;
    assign avl_read       = w_read;
    assign avl_address    = r_base + ADDR_W'(r_issue_cnt);
    assign avl_write      = 1'b0;
    assign avl_writedata  = '0;
    assign avl_burstbegin = avl_read || avl_write;

endmodule

// File: tb/tb_mask_stream_loader.sv
// Bench for mask_stream_loader: fixed-latency memory model with a scoreboard of expected
// addresses and masks, a table of load scenarios, and sequences for timeout and reset.
module tb_mask_stream_loader;

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 26;
    localparam int NUM_BEATS = 9;
    localparam int MAX_OUT   = 4;
    localparam int TIMEOUT   = 1024;
    localparam int MASK_W    = NUM_BEATS * DATA_W;

    logic                 iCLK = 1'b0;
    logic                 reset = 1'b1;
    logic                 load_ddr = 1'b0;
    logic [ADDR_W-1:0]    start_address = '0;
    logic                 ready;
    logic                 done;
    logic                 error;
    logic [MASK_W-1:0]    mask;
    logic [ADDR_W-1:0]    avl_address;
    logic                 avl_read;
    logic                 avl_burstbegin;
    logic                 avl_write;
    logic [DATA_W-1:0]    avl_writedata;
    logic                 avl_wait_request_n = 1'b1;
    logic [DATA_W-1:0]    avl_readdata = '0;
    logic                 avl_readdatavalid = 1'b0;

    always #5 iCLK = ~iCLK;

    mask_stream_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_BEATS (NUM_BEATS),
        .MAX_OUT   (MAX_OUT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .iCLK               (iCLK),
        .reset              (reset),
        .load_ddr           (load_ddr),
        .start_address      (start_address),
        .ready              (ready),
        .done               (done),
        .error              (error),
        .mask               (mask),
        .avl_address        (avl_address),
        .avl_read           (avl_read),
        .avl_burstbegin     (avl_burstbegin),
        .avl_write          (avl_write),
        .avl_writedata      (avl_writedata),
        .avl_wait_request_n (avl_wait_request_n),
        .avl_readdata       (avl_readdata),
        .avl_readdatavalid  (avl_readdatavalid)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Scoreboard and memory-model state
    logic [ADDR_W-1:0] exp_addr[$];
    logic [MASK_W-1:0] exp_mask[$];
    logic [ADDR_W-1:0] pend_addr[$];
    int                pend_due[$];
    logic [MASK_W-1:0] cur_mask = '0;
    logic [ADDR_W-1:0] stall_addr = '0;
    int cur_lat = 3, stall_len = 0, stall_cnt = 0, stall_idx = 2;
    int issue_idx = 0, beat_cnt = 0, model_out = 0, mute_after = 1000;
    int last_evt = 0, load_cyc = 0, exp_rel = -1, done_seen = 0;
    bit started = 1'b0;
    bit late_beat = 1'b0;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {6'h15, a, 6'h2a, ~a, 6'h00, a, 6'h3f, a ^ 26'h1555555};
    endfunction

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not match expectation (cycle %0d)", name, cyc);
    endtask

    task automatic chk_word(input string name, input logic [DATA_W-1:0] act,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One comparison per mask; reports the first differing word.
    task automatic mask_chk(input string name, input logic [MASK_W-1:0] act,
                            input logic [MASK_W-1:0] exp);
        int  k_bad = 0;
        bit  found = 1'b0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            if (!found && (act[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W])) begin
                k_bad = k;
                found = 1'b1;
            end
        end
        chk_word($sformatf("%s word%0d", name, k_bad), act[k_bad*DATA_W +: DATA_W],
                 exp[k_bad*DATA_W +: DATA_W]);
    endtask

    // Memory model, request scoreboard and done/mask monitor, all away from the rising edge.
    always @(negedge iCLK) begin
        logic [ADDR_W-1:0] a;
        logic [MASK_W-1:0] m;
        int                due;
        logic              acc;
        avl_readdatavalid  = 1'b0;
        avl_readdata       = '0;
        avl_wait_request_n = 1'b1;
        if (late_beat) begin
            avl_readdatavalid = 1'b1;
            avl_readdata      = word_of(26'h123);
            late_beat         = 1'b0;
        end
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            a   = pend_addr.pop_front();
            due = pend_due.pop_front();
            if (beat_cnt < mute_after) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = word_of(a);
                beat_cnt++;
                model_out--;
                last_evt = cyc;
            end
        end
        if (started && !reset && avl_read && issue_idx == stall_idx && stall_cnt < stall_len) begin
            avl_wait_request_n = 1'b0;
            stall_cnt++;
            chk_word("stall_addr_hold", DATA_W'(avl_address), DATA_W'(stall_addr));
        end
        acc = avl_read && avl_wait_request_n;
        if (acc) begin
            pend_addr.push_back(avl_address);
            pend_due.push_back(cyc + cur_lat);
        end
        if (started && !reset) begin
            chk_bit("burstbegin", avl_burstbegin, avl_read || avl_write);
            if (acc) begin
                if (exp_addr.size() == 0) fail("unexpected_request");
                else chk_word("req_addr", DATA_W'(avl_address), DATA_W'(exp_addr.pop_front()));
                issue_idx++;
                model_out++;
                last_evt = cyc;
                chk_bit("outstanding_bound", model_out <= MAX_OUT, 1'b1);
            end
            if (done) begin
                done_seen++;
                if (exp_mask.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    m = exp_mask.pop_front();
                    mask_chk("mask_commit", mask, m);
                    cur_mask = m;
                end
                chk_bit("ready_at_done", ready, 1'b1);
                if (exp_rel >= 0) chk_int("done_cycle", cyc - load_cyc, exp_rel);
            end else begin
                mask_chk("mask_stable", mask, cur_mask);
            end
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic start_load(input logic [ADDR_W-1:0] sa, input int lat, input int stall,
                              input int rel);
        logic [MASK_W-1:0] m;
        logic [ADDR_W-1:0] a;
        chk_bit("ready_before_load", ready, 1'b1);
        cur_lat    = lat;
        stall_len  = stall;
        stall_cnt  = 0;
        stall_addr = sa + 26'd2;
        issue_idx  = 0;
        beat_cnt   = 0;
        model_out  = 0;
        exp_rel    = rel;
        for (int k = 0; k < NUM_BEATS; k++) begin
            a = sa + ADDR_W'(k);
            exp_addr.push_back(a);
            m[k*DATA_W +: DATA_W] = word_of(a);
        end
        exp_mask.push_back(m);
        load_cyc      = cyc;
        start_address = sa;
        load_ddr      = 1'b1;
        step();
        load_ddr      = 1'b0;
        start_address = '1;
        chk_bit("ready_low_cycle1", ready, 1'b0);
        chk_bit("read_cycle1", avl_read, 1'b1);
        chk_bit("error_cleared", error, 1'b0);
    endtask

    task automatic wait_done(input int bound);
        int d0 = done_seen;
        int n  = 0;
        while (done_seen == d0 && n < bound) begin
            step();
            n++;
        end
        if (done_seen == d0) fail("done_timeout");
        chk_bit("done_low_after", done, 1'b0);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] sa;
        int                lat;
        int                stall;
        int                done_rel;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d0;
        int n;
        vecs[0] = '{26'h0000100, 3, 0, 14};
        vecs[1] = '{26'h3FFFFFE, 1, 0, 12};
        vecs[2] = '{26'h0002000, 2, 0, 13};
        vecs[3] = '{26'h0000055, 4, 0, 17};
        vecs[4] = '{26'h0000000, 5, 0, 20};
        vecs[5] = '{26'h0004000, 3, 5, 19};
        vecs[6] = '{26'h3FFFFF9, 2, 2, 15};

        repeat (3) step();
        reset   = 1'b0;
        started = 1'b1;
        chk_bit("rst_ready", ready, 1'b1);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_error", error, 1'b0);
        chk_bit("rst_read", avl_read, 1'b0);
        chk_bit("rst_write", avl_write, 1'b0);
        chk_word("rst_addr", DATA_W'(avl_address), '0);
        chk_word("rst_wdata", avl_writedata, '0);
        mask_chk("rst_mask", mask, '0);
        step();

        for (int i = 0; i < 7; i++) begin
            start_load(vecs[i].sa, vecs[i].lat, vecs[i].stall, vecs[i].done_rel);
            wait_done(200);
            step();
        end

        // Watchdog abort after four returned beats.
        mute_after = 4;
        d0 = done_seen;
        start_load(26'h0000700, 3, 0, -1);
        n = 0;
        while (!error && n < TIMEOUT + 100) begin
            step();
            n++;
        end
        if (!error) fail("timeout_never_fired");
        else chk_int("timeout_cycle", cyc, last_evt + TIMEOUT + 1);
        chk_bit("abort_ready", ready, 1'b1);
        chk_bit("abort_read", avl_read, 1'b0);
        exp_mask.delete();
        exp_addr.delete();
        mute_after = 1000;
        late_beat  = 1'b1;
        repeat (3) step();
        chk_bit("error_sticky", error, 1'b1);
        chk_bit("late_beat_ready", ready, 1'b1);
        chk_int("no_done_on_abort", done_seen, d0);
        start_load(26'h0000780, 3, 0, 14);
        wait_done(200);
        step();

        // Busy request during RUN is dropped, not queued.
        start_load(26'h0000800, 3, 0, 14);
        repeat (4) step();
        load_ddr = 1'b1;
        step();
        load_ddr = 1'b0;
        wait_done(200);
        repeat (5) begin
            chk_bit("no_queued_load", avl_read, 1'b0);
            step();
        end

        // Reset mid-load, then trailing beats must be ignored.
        start_load(26'h0000900, 4, 0, -1);
        repeat (5) step();
        reset = 1'b1;
        exp_addr.delete();
        exp_mask.delete();
        cur_mask = '0;
        d0 = done_seen;
        step();
        reset = 1'b0;
        chk_bit("midrst_ready", ready, 1'b1);
        chk_bit("midrst_read", avl_read, 1'b0);
        chk_bit("midrst_done", done, 1'b0);
        mask_chk("midrst_mask", mask, '0);
        repeat (12) step();
        mask_chk("trailing_mask", mask, '0);
        chk_bit("trailing_ready", ready, 1'b1);
        chk_int("trailing_no_done", done_seen, d0);

        start_load(26'h0000010, 3, 0, 14);
        wait_done(200);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
